lab_counter: RTL and testbench
==============================

Name: lab_counter

Overview:
- 8-bit loadable up-counter for the toy processor datapath; serves as a program/sequence counter.
- On each rising clock edge it does one of three things: loads a parallel value, increments by one, or holds.
- The increment is built as a ripple chain of half adders.
- Asynchronous active-low reset forces the count to zero.

Parameters:
- WIDTH, 8, bit width of Count_in and Count_out. The bench uses only 8.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Count_in  input  WIDTH  parallel load value.
- Load  input  1  synchronous load enable, active-high.
- count  input  1  synchronous count enable, active-high.
- Count_out  output  WIDTH  current counter value, driven directly from the state register.

Behaviour:
- One clock domain (CLK) and one state register of WIDTH bits; Count_out equals that register.
- Reset:
  - Reset low forces the register to 0 immediately (asynchronous), without waiting for a clock edge.
  - While Reset is held low, Count_out stays 0 and CLK, Load and count are ignored.
  - When Reset is released (goes high), operation resumes at the next rising CLK edge.
  - Reset value of Count_out is 0x00.
- Priority at each rising CLK edge while Reset is high:
  1. Load=1: register <= Count_in. Load wins over count when both are 1.
  2. Load=0, count=1: register <= register + 1.
  3. Load=0, count=0: register holds its value.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - 0xFF + 1 wraps to 0x00.
  - There is no carry or terminal-count output.
- Incrementer structure:
  - WIDTH cascaded half adders with carry-in = 1 at bit 0.
  - sum_i = q_i XOR c_i; c_{i+1} = q_i AND c_i.
  - The final carry is discarded.
  - Implement the half adder as a separate submodule instantiated WIDTH times with a generate loop.
- Latency:
  - Load and increment results appear on Count_out one clock edge after the controls are sampled.
  - No combinational path from Count_in, Load or count to Count_out.
- Control inputs are sampled only at rising CLK edges. Changes between edges have no effect.
- Reset mid-operation:
  - Asserting Reset during a count or load sequence aborts it and zeroes the output at once.
  - A Load or count that is high on the first clock edge after release takes effect normally.
- Never produce X on Count_out after reset, regardless of the Count_in value.

Test Plan:
- Async reset: set register to 0x5A, drive Reset low halfway between clock edges -> Count_out becomes 0x00 before the next edge. Hold Reset low for 3 edges with Load=1 and Count_in=0xFF -> output stays 0x00.
- Load/count sweep: Reset=1, Count_in=0xFF. Step {count,Load} through 00,01,10,11, one clock each, starting from 0x00:
  - 00 -> holds 0x00.
  - 01 -> 0xFF.
  - 10 -> 0x00 (wrap).
  - 11 -> 0xFF (load priority).
- Count with wrap: load 0xFB, then Load=0, count=1 for 6 edges -> 0xFC, 0xFD, 0xFE, 0xFF, 0x00, 0x01.
- Hold: load 0x3C, Load=0, count=0 for 4 edges -> stays 0x3C. Toggle Count_in meanwhile -> no effect.
- Carry ripple: load 0x0F and 0x7F, count once each -> 0x10 and 0x80.
- Reset during counting: count up from 0x10, assert Reset for a partial cycle after 3 increments, release with count=1 -> 0x13, then 0x00, then 0x01 on the first edge after release.

Source files
------------

// File: rtl/lab_counter.sv
// 8-bit loadable up-counter for the toy processor datapath.
// Loads a parallel value, increments through a half-adder ripple chain, or holds.

module lab_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

module lab_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Count_in,
    input  logic             Load,
    input  logic             count,
    output logic [WIDTH-1:0] Count_out
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] inc_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] carry_s;
    logic             final_carry_unused_s;

    // Carry-in of one at bit 0 turns the half-adder chain into a +1 incrementer.
    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_inc
        if (i < WIDTH - 1) begin : g_mid
            lab_half_adder u_ha (
                .a     (count_r[i]),
                .b     (carry_s[i]),
                .sum   (inc_s[i]),
                .carry (carry_s[i+1])
            );
        end else begin : g_last
            // Carry out of the top bit is dropped, giving modulo-2^WIDTH wrap.
            lab_half_adder u_ha (
                .a     (count_r[i]),
                .b     (carry_s[i]),
                .sum   (inc_s[i]),
                .carry (final_carry_unused_s)
            );
        end
    end

    // Next-state select: load has priority over increment, otherwise hold.
    always_comb begin
        next_s = count_r;
        if (Load) begin
            next_s = Count_in;
        end else if (count) begin
            next_s = inc_s;
        end else begin
            next_s = count_r;
        end
    end

    // Counter state register with asynchronous clear.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= next_s;
        end
    end

    assign Count_out = count_r;

endmodule

// File: tb/tb_lab_counter.sv
// Directed self-checking bench for lab_counter: reset, load/count priority,
// wrap, hold, carry ripple and reset in mid-sequence.

module tb_lab_counter;

    logic       CLK;
    logic       Reset;
    logic [7:0] Count_in;
    logic       Load;
    logic       count;
    logic [7:0] Count_out;

    int checks = 0;
    int errors = 0;

    lab_counter #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Count_in  (Count_in),
        .Load      (Load),
        .count     (count),
        .Count_out (Count_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] expected);
        checks++;
        assert (Count_out === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, Count_out, expected);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    logic [7:0] wrap_exp [6];

    initial begin
        wrap_exp[0] = 8'hFC; wrap_exp[1] = 8'hFD; wrap_exp[2] = 8'hFE;
        wrap_exp[3] = 8'hFF; wrap_exp[4] = 8'h00; wrap_exp[5] = 8'h01;

        Reset = 1'b0; Load = 1'b0; count = 1'b0; Count_in = 8'h00;
        tick();
        check("reset_value", 8'h00);

        Reset = 1'b1;
        Count_in = 8'h5A; Load = 1'b1;
        tick();
        check("load_5a", 8'h5A);

        // Async reset between edges, then held with load active.
        #2 Reset = 1'b0;
        #1 check("async_reset_immediate", 8'h00);
        Load = 1'b1; Count_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_held", 8'h00);
        end
        Reset = 1'b1;

        // Sweep {count,Load} with Count_in = 0xFF.
        {count, Load} = 2'b00;
        tick();
        check("sweep_00_hold", 8'h00);
        {count, Load} = 2'b01;
        #1 check("no_comb_path", 8'h00);
        tick();
        check("sweep_01_load", 8'hFF);
        {count, Load} = 2'b10;
        tick();
        check("sweep_10_wrap", 8'h00);
        {count, Load} = 2'b11;
        tick();
        check("sweep_11_load_priority", 8'hFF);

        // Count through wrap from 0xFB.
        Count_in = 8'hFB; Load = 1'b1; count = 1'b0;
        tick();
        check("load_fb", 8'hFB);
        Load = 1'b0; count = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("count_wrap", wrap_exp[i]);
        end

        // Hold while Count_in toggles.
        Count_in = 8'h3C; Load = 1'b1; count = 1'b0;
        tick();
        check("load_3c", 8'h3C);
        Load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Count_in = (i % 2 == 0) ? 8'hA5 : 8'h5A;
            #2 Count_in = ~Count_in;
            tick();
            check("hold_3c", 8'h3C);
        end

        // Carry ripple across nibble and into the MSB.
        Count_in = 8'h0F; Load = 1'b1; count = 1'b0;
        tick();
        Load = 1'b0; count = 1'b1;
        tick();
        check("ripple_0f", 8'h10);
        Count_in = 8'h7F; Load = 1'b1; count = 1'b0;
        tick();
        Load = 1'b0; count = 1'b1;
        tick();
        check("ripple_7f", 8'h80);

        // Reset during counting, released before the next edge with count high.
        Count_in = 8'h10; Load = 1'b1; count = 1'b0;
        tick();
        Load = 1'b0; count = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("count_to_13", 8'h13);
        #2 Reset = 1'b0;
        #1 check("midcount_reset", 8'h00);
        #1 Reset = 1'b1;
        tick();
        check("first_edge_after_release", 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
